// File: rtl/vfx_frame_scheduler.sv
// vfx_frame_scheduler: frame framing/repair and frame-stable filter select.
// Optional feature macro: VFX_SEL_OVERRIDE_EN (adds sel_override_en/sel_override).
module vfx_frame_scheduler #(
    parameter int DATA_W      = 12,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int HOLD_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        freq_flag,
`ifdef VFX_SEL_OVERRIDE_EN
    input  logic              sel_override_en,
    input  logic [1:0]        sel_override,
`endif
    input  logic              valid_in,
    input  logic              startofpacket_in,
    input  logic              endofpacket_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        filter_sel,
    output logic              frame_active,
    output logic              frame_error,
    output logic [15:0]       frame_count
);
    localparam int N      = IMG_W * IMG_H;
    localparam int PIX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t            r_state, w_state_nxt;
    logic [PIX_W-1:0]  r_pix_cnt, w_pix_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [1:0]        r_cand, w_cand_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic [15:0]       r_fcnt, w_fcnt_nxt;
    logic              r_err, w_err_nxt;
    logic              w_ready, w_valid, w_eop, w_fire, w_last;

    assign w_last = (r_pix_cnt == PIX_LAST);
    assign w_fire = valid_in & w_ready;

    // Zero-latency handshake/sideband path, shaped by the frame state
    always_comb begin
        w_ready = 1'b1;
        w_valid = 1'b0;
        w_eop   = endofpacket_in;
        unique case (r_state)
            S_IDLE: begin
                w_ready = startofpacket_in ? ready_in : 1'b1;
                w_valid = valid_in & startofpacket_in & ready_in;
            end
            S_ACTIVE: begin
                w_ready = ready_in;
                w_valid = valid_in;
                // Overrun: close the frame downstream on its last legal pixel
                if (w_last && !startofpacket_in) w_eop = 1'b1;
            end
            S_FLUSH: begin
                // A fresh sop restarts a frame, so it must reach the filter
                if (startofpacket_in && !endofpacket_in) begin
                    w_ready = ready_in;
                    w_valid = valid_in & ready_in;
                end
            end
            default: ;
        endcase
    end

    // Next state, pixel counting, fault detection and select hysteresis
    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix_cnt;
        w_sel_nxt   = r_sel;
        w_cand_nxt  = r_cand;
        w_hold_nxt  = r_hold;
        w_fcnt_nxt  = r_fcnt;
        w_err_nxt   = 1'b0;
        w_hold_inc  = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;
        if (w_fire) begin
            unique case (r_state)
                S_IDLE: begin
                    if (startofpacket_in && endofpacket_in) begin
                        w_err_nxt = 1'b1;
                    end else if (startofpacket_in) begin
                        w_state_nxt = S_ACTIVE;
                        w_pix_nxt   = PIX_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (endofpacket_in) begin
                        w_state_nxt = S_IDLE;
                    end else if (startofpacket_in) begin
                        w_state_nxt = S_ACTIVE;
                        w_pix_nxt   = PIX_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (startofpacket_in) begin
                        w_err_nxt  = 1'b1;
                        w_hold_nxt = '0;
                        if (endofpacket_in) w_state_nxt = S_IDLE;
                        else w_pix_nxt = PIX_W'(1);
                    end else if (endofpacket_in) begin
                        w_state_nxt = S_IDLE;
                        if (w_last) begin
                            w_fcnt_nxt = r_fcnt + 16'd1;
                            if (freq_flag == r_cand) begin
                                w_hold_nxt = w_hold_inc;
                            end else begin
                                w_cand_nxt = freq_flag;
                                w_hold_nxt = HOLD_W'(1);
                            end
                            if (w_hold_nxt >= HOLD_MAX && w_cand_nxt != r_sel)
                                w_sel_nxt = w_cand_nxt;
                        end else begin
                            w_err_nxt  = 1'b1;
                            w_hold_nxt = '0;
                        end
                    end else if (w_last) begin
                        w_err_nxt   = 1'b1;
                        w_hold_nxt  = '0;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_pix_nxt = r_pix_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef VFX_SEL_OVERRIDE_EN
        if (w_fire && startofpacket_in && r_state != S_ACTIVE && sel_override_en) begin
            w_sel_nxt  = sel_override;
            w_cand_nxt = sel_override;
            w_hold_nxt = HOLD_MAX;
        end
`endif
    end

    // Control registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pix_cnt <= '0;
            r_sel     <= '0;
            r_cand    <= '0;
            r_hold    <= '0;
            r_fcnt    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= w_pix_nxt;
            r_sel     <= w_sel_nxt;
            r_cand    <= w_cand_nxt;
            r_hold    <= w_hold_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign ready_out         = w_ready;
    assign valid_out         = w_valid;
    assign startofpacket_out = startofpacket_in;
    assign endofpacket_out   = w_eop;
    assign data_out          = data_in;
    assign filter_sel        = r_sel;
    assign frame_active      = (r_state == S_ACTIVE);
    assign frame_error       = r_err;
    assign frame_count       = r_fcnt;
endmodule

// File: doc/vfx_frame_scheduler.md
Name: vfx_frame_scheduler

Overview:
- Frame-level controller in front of the effect filter datapath (blur/edge filters) on the 12-bit RGB444 Avalon-ST video stream.
- Tracks packet framing and pixel count, and drops beats received outside a frame.
- Detects malformed frames and repairs them so the downstream filter always receives exactly one sop and one eop per frame.
- Turns the audio freq_flag into a filter_sel that is held stable for a whole frame, using frame-count hysteresis.

Parameters:
- DATA_W, 12, pixel width (RGB444).
- IMG_W, 320, pixels per line.
- IMG_H, 240, lines per frame.
- HOLD_FRAMES, 4, consecutive clean frames a new freq_flag value must persist before it is committed (must be ≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- freq_flag  in  2  audio frequency band request
- valid_in  in  1  upstream beat valid
- startofpacket_in  in  1  upstream sop
- endofpacket_in  in  1  upstream eop
- data_in  in  DATA_W  upstream pixel
- ready_out  out  1  ready to upstream
- ready_in  in  1  ready from downstream filter
- valid_out  out  1  beat valid to filter
- startofpacket_out  out  1  sop to filter
- endofpacket_out  out  1  eop to filter
- data_out  out  DATA_W  pixel to filter (equals data_in)
- filter_sel  out  2  committed effect select, stable within a frame
- frame_active  out  1  high while in ACTIVE state
- frame_error  out  1  one-cycle pulse on a framing fault
- frame_count  out  16  clean frames completed, wraps at 65535→0

Behaviour:
- Zero latency: data, valid, sop, eop and ready paths are combinational.
- Control state (state, counters, filter_sel, candidate, hold count, frame_error) is registered.
- Accept condition: fire = valid_in & ready_out.
- Reset values: state=IDLE, pix_cnt=0, filter_sel=0, cand=0, hold_cnt=0, frame_count=0, frame_error=0, frame_active=0. Combinational outputs follow from IDLE.
- Reset asserted mid-frame: abandon the frame immediately with no eop synthesis and no error pulse.
- N = IMG_W*IMG_H. pix_cnt is wide enough to hold N-1.
- frame_error defaults to 0 every cycle unless set by a fault below.

IDLE:
- ready_out=1.
- valid_out = valid_in & startofpacket_in & ready_in.
- ready_out = ready_in when startofpacket_in, else 1: non-sop beats are silently dropped.
- Accepted sop → ACTIVE, pix_cnt=1.
- sop & eop on the same beat (1-pixel frame, N>1): frame_error, stay IDLE, eop_out passed through.

ACTIVE:
- ready_out=ready_in, valid_out=valid_in, sop/eop pass through except as noted.
- Accepted beat with eop and pix_cnt==N-1: clean end → IDLE, frame_count+1, hysteresis update.
- Accepted eop with pix_cnt<N-1: early end → frame_error, IDLE, hold_cnt=0.
- Accepted sop (premature new frame): frame_error, hold_cnt=0, pix_cnt=1, stay ACTIVE. Downstream sees the new sop directly.
- Accepted beat at pix_cnt==N-1 without eop: force endofpacket_out=1 on that beat, frame_error, → FLUSH.
- Otherwise pix_cnt+1.

FLUSH:
- ready_out=1, valid_out=0. Discard beats through the first accepted eop inclusive, then → IDLE.
- A sop seen in FLUSH (without eop) → ACTIVE as in IDLE.

Hysteresis, on a clean end only:
- If freq_flag==cand: hold_cnt = min(hold_cnt+1, HOLD_FRAMES).
- Else: cand=freq_flag, hold_cnt=1.
- If the new hold_cnt ≥ HOLD_FRAMES and cand≠filter_sel: filter_sel=cand on the same edge.
- filter_sel therefore never changes between sop and eop. It changes only on the clock edge that accepts a clean eop.

Optional Feature:
- Macro: VFX_SEL_OVERRIDE_EN.
- With the macro defined, add inputs sel_override_en (1) and sel_override (2).
- While sel_override_en=1, the next accepted sop in IDLE or FLUSH loads filter_sel=sel_override. The datapath sees the new value from the following beat; the sop beat itself uses the old value.
- The override also sets cand=sel_override and hold_cnt=HOLD_FRAMES, and bypasses hysteresis.
- Without the macro: ports absent, filter_sel is driven only by hysteresis.

Test Plan (IMG_W=4, IMG_H=2, N=8, HOLD_FRAMES=2):
- Reset, then 3 clean 8-beat frames with freq_flag=0 → no frame_error, frame_count=3, filter_sel=0, outputs bit-identical to inputs.
- freq_flag=2 over 2 clean frames → filter_sel=0 after frame 1 eop, 2 on the frame 2 eop edge. Toggling freq_flag 1/3 every frame → filter_sel never changes.
- eop on beat 5 → frame_error pulse, frame_count unchanged, next frame accepted normally. Then 10 beats without eop → eop_out forced on beat 8, beats 9–10 dropped (valid_out=0).
- ready_in held low 3 cycles mid-frame → ready_out low, pix_cnt frozen, no beats lost. 4 non-sop beats in IDLE → valid_out=0, ready_out=1.
- Second sop at beat 4 → frame_error, pix_cnt restarts, that frame ends cleanly at beat 8 after the new sop. Reset asserted at beat 3 → all registers return to reset values asynchronously.
- With VFX_SEL_OVERRIDE_EN: sel_override_en=1, sel_override=3, next sop → filter_sel=3 within one cycle regardless of freq_flag.
